operand_issue: RTL and testbench
================================

// Module: operand_issue
// PURPOSE
//  Decode-to-execute operand fetch and issue stage of the RV64 pipeline.
//  - Drives the register file read addresses and gathers the rs1/rs2 values.
//  - Patches stale values with bypasses from the EX, MEM and WB stages.
//  - Holds the instruction on a load-use hazard.
//  - Registers the issued operands into a valid/ready skid-free pipeline register feeding EX.
// PARAMETERS
//  XLEN     64  datapath width
//  REG_NUM  32  architectural registers; address width is $clog2(REG_NUM) = 5
//  CNT_W    32  width of the hazard-stall performance counter
// PORTS
//  clk            in   1     clock, all state updates on posedge
//  rst            in   1     synchronous reset, active high
//  flush          in   1     pipeline redirect; kills the held output and the incoming instr
//  in_valid       in   1     decoded instruction present
//  in_ready       out  1     this stage accepts the instruction this cycle
//  in_pc          in   XLEN  instruction PC
//  in_rs1/in_rs2  in   5     source register indices
//  in_use_rs1/2   in   1     instruction actually reads rs1/rs2
//  in_rd          in   5     destination register index
//  in_rd_we       in   1     instruction writes rd
//  in_imm         in   XLEN  sign-extended immediate
//  rf_raddr0/1    out  5     register file read addresses (= in_rs1/in_rs2, combinational)
//  rf_rdata0/1    in   XLEN  register file read data (combinational, pre-write values)
//  ex_fwd_valid   in   1     EX holds an instr writing ex_fwd_rd
//  ex_fwd_rd      in   5     EX destination register
//  ex_fwd_ok      in   1     EX result available (0 for a load in EX)
//  ex_fwd_data    in   XLEN  EX result
//  mem_fwd_valid, mem_fwd_rd, mem_fwd_ok, mem_fwd_data
//                 in   1/5/1/XLEN  same meaning for the MEM stage
//  wb_we          in   1     WB write enable (same net as the RF write port)
//  wb_rd          in   5     WB destination register
//  wb_data        in   XLEN  WB write data
//  out_valid      out  1     issued instruction valid toward EX
//  out_ready      in   1     EX accepts out_* this cycle
//  out_pc, out_imm          out  XLEN  registered copies of the inputs
//  out_rs1_val, out_rs2_val out  XLEN  resolved operands
//  out_rd         out  5     registered destination register index
//  out_rd_we      out  1     registered rd write enable
//  stall_cnt      out  CNT_W cycles with in_valid=1 held by a data hazard
// BEHAVIOUR
//  - Operand select, per source s, priority high to low:
//    1. idx==0 -> 0.
//    2. ex_fwd_valid & ex_fwd_rd==idx -> ex_fwd_data.
//    3. mem_fwd_valid & rd match -> mem_fwd_data.
//    4. wb_we & wb_rd==idx -> wb_data. Required: the RF write lands only at the clock edge.
//    5. Otherwise rf_rdata.
//  - Hazard: in_use_s=1, idx!=0, and the highest-priority matching stage has fwd_ok=0.
//    - A match in a lower-priority stage is ignored when a higher stage matches.
//  - can_load = !out_valid | out_ready.
//  - in_ready = !hazard & can_load & !flush.
//  - accept = in_valid & in_ready.
//  - Output register, evaluated at posedge in priority order:
//    1. rst: all out_* = 0, out_valid = 0, stall_cnt = 0.
//    2. flush: out_valid <= 0. The incoming instr is dropped. stall_cnt is unchanged.
//    3. accept: out_* <= resolved values, out_valid <= 1.
//    4. out_ready: out_valid <= 0.
//    5. Otherwise hold all outputs unchanged.
//  - Timing: latency is 1 cycle in to out. Full throughput is 1 instr/cycle when out_ready=1.
//  - Output stability: out_* must stay stable while out_valid & !out_ready.
//  - stall_cnt increments when in_valid & hazard & !flush. It saturates at all-ones (no wrap).
//  - Reset has priority over everything, including a mid-handshake accept.
// TESTING
//  1. Bypass priority: x5 matched in all of EX=0xA, MEM=0xB, WB=0xC; RF=0xD.
//     -> out_rs1_val=0xA. Drop EX -> 0xB. Drop MEM -> 0xC. Drop WB -> 0xD.
//  2. Load-use: EX load to x7 with ex_fwd_ok=0; instr uses rs2=x7.
//     -> in_ready=0 for 1 cycle, stall_cnt +1.
//     -> Load moves to MEM with ok=1: accepted, out_rs2_val = mem data.
//  3. x0 source with EX fwd_rd=0, ok=0 -> no stall, operand value 0.
//  4. Backpressure: out_ready=0 for 3 cycles while out_valid=1.
//     -> in_ready=0 and out_* stable. Then out_ready=1 -> next instr issues the following cycle.
//  5. Flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0; the incoming instr never appears.
//  6. Reset asserted mid-stall after stall_cnt=4 -> out_valid=0, all out_*=0, stall_cnt=0.
//     Saturation: preload all-ones (force), continue stalling -> stays all-ones.

Source files
------------

// File: rtl/operand_issue.sv
// Operand fetch/issue stage: reads the register file, patches operands from the
// EX/MEM/WB bypass network, holds on load-use hazards and registers the result for EX.
module operand_issue #(
    parameter int XLEN    = 64,
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 32,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rd_we,
    input  logic [XLEN-1:0] in_imm,

    output logic [AW-1:0]   rf_raddr0,
    output logic [AW-1:0]   rf_raddr1,
    input  logic [XLEN-1:0] rf_rdata0,
    input  logic [XLEN-1:0] rf_rdata1,

    input  logic            ex_fwd_valid,
    input  logic [AW-1:0]   ex_fwd_rd,
    input  logic            ex_fwd_ok,
    input  logic [XLEN-1:0] ex_fwd_data,

    input  logic            mem_fwd_valid,
    input  logic [AW-1:0]   mem_fwd_rd,
    input  logic            mem_fwd_ok,
    input  logic [XLEN-1:0] mem_fwd_data,

    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [AW-1:0]   out_rd,
    output logic            out_rd_we,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            hazard;
    logic            can_load;
    logic            accept;

    // Returns {pending, value}; only the youngest matching producer decides, so an
    // unready EX load blocks even when an older stage holds a usable copy.
    function automatic logic [XLEN:0] resolve(input logic [AW-1:0] idx,
                                              input logic [XLEN-1:0] rf_val);
        logic [XLEN:0] r;
        if (idx == '0)
            r = '0;
        else if (ex_fwd_valid && ex_fwd_rd == idx)
            r = {!ex_fwd_ok, ex_fwd_data};
        else if (mem_fwd_valid && mem_fwd_rd == idx)
            r = {!mem_fwd_ok, mem_fwd_data};
        else if (wb_we && wb_rd == idx)
            r = {1'b0, wb_data};
        else
            r = {1'b0, rf_val};
        return r;
    endfunction

    always_comb begin
        {rs1_pend, rs1_val} = resolve(in_rs1, rf_rdata0);
        {rs2_pend, rs2_val} = resolve(in_rs2, rf_rdata1);
    end

    assign rf_raddr0 = in_rs1;
    assign rf_raddr1 = in_rs2;

    assign hazard   = (in_use_rs1 && rs1_pend) || (in_use_rs2 && rs2_pend);
    assign can_load = !out_valid || out_ready;
    assign in_ready = !hazard && can_load && !flush;
    assign accept   = in_valid && in_ready;

    // Payload only changes on accept, which keeps out_* stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imm     <= in_imm;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating hazard-stall counter.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && hazard && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_operand_issue.sv
// Testbench for operand_issue: directed scenarios plus randomized traffic against
// a behavioural model of bypass selection, hazard stall and the output register.
module tb_operand_issue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_use_rs1, in_use_rs2, in_rd_we;
    logic [63:0] in_pc, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        ex_fwd_valid, ex_fwd_ok, mem_fwd_valid, mem_fwd_ok, wb_we, out_ready;
    logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_rd;
    logic [63:0] ex_fwd_data, mem_fwd_data, wb_data;
    logic [63:0] rf_rdata0, rf_rdata1, s_rf_rdata0, s_rf_rdata1;
    logic [4:0]  rf_raddr0, rf_raddr1, s_rf_raddr0, s_rf_raddr1;

    logic        in_ready, out_valid, out_rd_we;
    logic [63:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic [31:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_out_rd_we;
    logic [63:0] s_out_pc, s_out_imm, s_out_rs1_val, s_out_rs2_val;
    logic [4:0]  s_out_rd;
    logic [2:0]  stall_cnt_s;

    logic [63:0] rf_mem [32];
    assign rf_rdata0   = rf_mem[rf_raddr0];
    assign rf_rdata1   = rf_mem[rf_raddr1];
    assign s_rf_rdata0 = rf_mem[s_rf_raddr0];
    assign s_rf_rdata1 = rf_mem[s_rf_raddr1];

    operand_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_imm(in_imm),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_ok(ex_fwd_ok), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_ok(mem_fwd_ok), .mem_fwd_data(mem_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    operand_issue #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_imm(in_imm),
        .rf_raddr0(s_rf_raddr0), .rf_raddr1(s_rf_raddr1), .rf_rdata0(s_rf_rdata0), .rf_rdata1(s_rf_rdata1),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_ok(ex_fwd_ok), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_ok(mem_fwd_ok), .mem_fwd_data(mem_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_imm(s_out_imm),
        .out_rs1_val(s_out_rs1_val), .out_rs2_val(s_out_rs2_val), .out_rd(s_out_rd), .out_rd_we(s_out_rd_we),
        .stall_cnt(stall_cnt_s)
    );

    int          tests = 0;
    int          fails = 0;
    logic        seen_ready;
    logic        m_known = 1'b0;
    logic        m_valid, m_rd_we;
    logic [63:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [4:0]  m_rd;
    logic [31:0] m_cnt;
    logic [2:0]  m_cnt_s;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Producers listed youngest first; the first one naming idx supplies the value.
    function automatic void refOperand(input logic [4:0] idx, output logic [63:0] val, output logic pend);
        logic        v [3];
        logic [4:0]  r [3];
        logic        ok[3];
        logic [63:0] d [3];
        v = '{ex_fwd_valid, mem_fwd_valid, wb_we};
        r = '{ex_fwd_rd, mem_fwd_rd, wb_rd};
        ok = '{ex_fwd_ok, mem_fwd_ok, 1'b1};
        d = '{ex_fwd_data, mem_fwd_data, wb_data};
        val  = rf_mem[idx];
        pend = 1'b0;
        if (idx == 5'd0) begin
            val = '0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i] && r[i] == idx) begin
                val  = d[i];
                pend = !ok[i];
                return;
            end
        end
    endfunction

    task automatic clearInputs();
        {rst, flush, in_valid, in_use_rs1, in_use_rs2, in_rd_we} = '0;
        {in_pc, in_imm, in_rs1, in_rs2, in_rd} = '0;
        {ex_fwd_valid, ex_fwd_ok, mem_fwd_valid, mem_fwd_ok, wb_we, out_ready} = '0;
        {ex_fwd_rd, mem_fwd_rd, wb_rd, ex_fwd_data, mem_fwd_data, wb_data} = '0;
    endtask

    task automatic randInputs();
        rst           = ($urandom_range(99) == 0);
        flush         = ($urandom_range(15) == 0);
        in_valid      = ($urandom_range(3) != 0);
        in_pc         = {$urandom, $urandom};
        in_imm        = {$urandom, $urandom};
        in_rs1        = 5'($urandom_range(7));
        in_rs2        = 5'($urandom_range(7));
        in_use_rs1    = 1'($urandom);
        in_use_rs2    = 1'($urandom);
        in_rd         = 5'($urandom);
        in_rd_we      = 1'($urandom);
        ex_fwd_valid  = 1'($urandom);
        ex_fwd_rd     = 5'($urandom_range(7));
        ex_fwd_ok     = ($urandom_range(3) != 0);
        ex_fwd_data   = {$urandom, $urandom};
        mem_fwd_valid = 1'($urandom);
        mem_fwd_rd    = 5'($urandom_range(7));
        mem_fwd_ok    = ($urandom_range(3) != 0);
        mem_fwd_data  = {$urandom, $urandom};
        wb_we         = 1'($urandom);
        wb_rd         = 5'($urandom_range(7));
        wb_data       = {$urandom, $urandom};
        out_ready     = ($urandom_range(3) != 0);
    endtask

    // One clock: predict, check the combinational handshake, advance the model, check outputs.
    task automatic applyStimulus();
        logic [63:0] v1, v2, wr_data;
        logic        p1, p2, hz, exp_ready, acc, wr;
        logic [4:0]  wr_rd;
        #1;
        refOperand(in_rs1, v1, p1);
        refOperand(in_rs2, v2, p2);
        hz        = (in_use_rs1 && p1) || (in_use_rs2 && p2);
        exp_ready = !hz && (!m_valid || out_ready) && !flush;
        acc       = in_valid && exp_ready;
        seen_ready = in_ready;
        if (m_known) checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("rf_raddr", 64'({rf_raddr1, rf_raddr0}), 64'({in_rs2, in_rs1}));
        wr = wb_we; wr_rd = wb_rd; wr_data = wb_data;
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            {m_valid, m_rd_we, m_pc, m_imm, m_rs1, m_rs2, m_rd, m_cnt, m_cnt_s} = '0;
        end else begin
            if (in_valid && hz && !flush) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt_s != 3'd7) m_cnt_s = m_cnt_s + 1;
            end
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1; m_pc = in_pc; m_imm = in_imm;
                m_rs1 = v1; m_rs2 = v2; m_rd = in_rd; m_rd_we = in_rd_we;
            end else if (out_ready) m_valid = 1'b0;
        end
        @(negedge clk);
        if (wr) rf_mem[wr_rd] = wr_data;
        checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("out_pc", out_pc, m_pc);
        checkOutput("out_imm", out_imm, m_imm);
        checkOutput("out_rs1_val", out_rs1_val, m_rs1);
        checkOutput("out_rs2_val", out_rs2_val, m_rs2);
        checkOutput("out_rd", 64'(out_rd), 64'(m_rd));
        checkOutput("out_rd_we", 64'(out_rd_we), 64'(m_rd_we));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        checkOutput("stall_cnt_sat", 64'(stall_cnt_s), 64'(m_cnt_s));
    endtask

    initial begin
        clearInputs();
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        @(negedge clk);
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;

        // Bypass priority on x5.
        in_valid = 1'b1; in_rs1 = 5'd5; in_use_rs1 = 1'b1; out_ready = 1'b1; in_pc = 64'h40;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_ok = 1'b1; ex_fwd_data = 64'hA;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_ok = 1'b1; mem_fwd_data = 64'hB;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 64'hC;
        rf_mem[5] = 64'hD;
        applyStimulus();
        checkOutput("prio_ex", out_rs1_val, 64'hA);
        ex_fwd_valid = 1'b0;
        applyStimulus();
        checkOutput("prio_mem", out_rs1_val, 64'hB);
        mem_fwd_valid = 1'b0;
        applyStimulus();
        checkOutput("prio_wb", out_rs1_val, 64'hC);
        wb_we = 1'b0; rf_mem[5] = 64'hD;
        applyStimulus();
        checkOutput("prio_rf", out_rs1_val, 64'hD);

        // Load-use on x7, then the load resolves from MEM.
        in_rs1 = 5'd0; in_use_rs1 = 1'b0; in_rs2 = 5'd7; in_use_rs2 = 1'b1;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_ok = 1'b0;
        applyStimulus();
        checkOutput("lu_ready", 64'(seen_ready), 64'd0);
        checkOutput("lu_cnt", 64'(stall_cnt), 64'd1);
        ex_fwd_valid = 1'b0;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_ok = 1'b1; mem_fwd_data = 64'h77;
        applyStimulus();
        checkOutput("lu_ready2", 64'(seen_ready), 64'd1);
        checkOutput("lu_val", out_rs2_val, 64'h77);
        checkOutput("lu_cnt2", 64'(stall_cnt), 64'd1);

        // x0 source never stalls and reads as zero.
        mem_fwd_valid = 1'b0;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_ok = 1'b0;
        in_rs1 = 5'd0; in_use_rs1 = 1'b1; in_rs2 = 5'd0; in_use_rs2 = 1'b1;
        applyStimulus();
        checkOutput("x0_ready", 64'(seen_ready), 64'd1);
        checkOutput("x0_val", out_rs1_val, 64'd0);
        ex_fwd_valid = 1'b0;

        // Backpressure.
        in_pc = 64'h100;
        applyStimulus();
        checkOutput("bp_first", out_pc, 64'h100);
        out_ready = 1'b0; in_pc = 64'h200;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("bp_ready", 64'(seen_ready), 64'd0);
            checkOutput("bp_pc", out_pc, 64'h100);
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_issue", out_pc, 64'h200);

        // Flush kills held and incoming instructions.
        out_ready = 1'b0; flush = 1'b1; in_pc = 64'h300;
        applyStimulus();
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        applyStimulus();
        checkOutput("flush_gone", 64'(out_valid), 64'd0);
        checkOutput("flush_pc", out_pc, 64'h200);

        // Reset mid-stall, then saturation of the narrow counter.
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0; in_valid = 1'b1; in_pc = 64'h400; in_use_rs1 = 1'b0; in_use_rs2 = 1'b0;
        applyStimulus();
        in_rs2 = 5'd7; in_use_rs2 = 1'b1;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_ok = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("mid_cnt", 64'(stall_cnt), 64'd4);
        checkOutput("mid_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        applyStimulus();
        checkOutput("rst2_valid", 64'(out_valid), 64'd0);
        checkOutput("rst2_pc", out_pc, 64'd0);
        checkOutput("rst2_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("sat_wide", 64'(stall_cnt), 64'd10);
        checkOutput("sat_narrow", 64'(stall_cnt_s), 64'd7);

        for (int i = 0; i < 3000; i++) begin
            randInputs();
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
